// File: rtl/locker.sv
// Serial 4-digit password locker. It has a user password that can be changed,
// a fixed administrator password, lockout after three failures, and a
// 7-segment echo of the last digit taken.
module locker #(
    parameter logic [15:0] DEFAULT_PWD = 16'h0103,
    parameter logic [15:0] ADMIN_PWD   = 16'h0207
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Code,
    input  logic       Mode,
    output logic       Unlock,
    output logic       Err,
    output logic       alert,
    output logic [6:0] digits
);

    logic        mode_q;
    logic [1:0]  idx;
    logic [1:0]  idx_eff;
    logic [11:0] cap;
    logic [15:0] pwd;
    logic [15:0] entry;
    logic [1:0]  fail_cnt;
    logic        ignore;
    logic        user_ok;
    logic        admin_ok;

    // Hex glyph for the 7-segment display, active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        s = 7'b0000000;
        case (d)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // A change of Mode restarts the sequence, so this digit becomes digit 1.
    // While locked out, set-mode digits are dropped completely.
    // The 4th digit is compared together with the three captured digits.
    always_comb begin
        idx_eff  = (Mode != mode_q) ? 2'd0 : idx;
        ignore   = !Mode && alert;
        entry    = {cap, Code};
        user_ok  = (entry == pwd);
        admin_ok = (entry == ADMIN_PWD);
    end

    // Digit capture, password compare or update, failure counting and lockout.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q   <= Mode;
            idx      <= 2'd0;
            cap      <= 12'h000;
            pwd      <= DEFAULT_PWD;
            fail_cnt <= 2'd0;
            Unlock   <= 1'b0;
            Err      <= 1'b0;
            alert    <= 1'b0;
            digits   <= seg(4'h0);
        end else begin
            mode_q <= Mode;
            if (ignore) begin
                idx <= 2'd0;
            end else begin
                digits <= seg(Code);
                idx    <= idx_eff + 2'd1;
                case (idx_eff)
                    2'd0: begin
                        cap[11:8] <= Code;
                        Unlock    <= 1'b0;
                        Err       <= 1'b0;
                    end
                    2'd1: cap[7:4] <= Code;
                    2'd2: cap[3:0] <= Code;
                    default: begin
                        if (!Mode) begin
                            pwd    <= entry;
                            Unlock <= 1'b0;
                            Err    <= 1'b0;
                        end else if (alert) begin
                            if (admin_ok) begin
                                Unlock   <= 1'b1;
                                Err      <= 1'b0;
                                alert    <= 1'b0;
                                fail_cnt <= 2'd0;
                            end else begin
                                Unlock <= 1'b0;
                                Err    <= 1'b1;
                            end
                        end else if (user_ok || admin_ok) begin
                            Unlock   <= 1'b1;
                            Err      <= 1'b0;
                            fail_cnt <= 2'd0;
                        end else begin
                            Unlock <= 1'b0;
                            Err    <= 1'b1;
                            if (fail_cnt != 2'd3) fail_cnt <= fail_cnt + 2'd1;
                            if (fail_cnt >= 2'd2) alert <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_locker.sv
// Directed bench for locker. Stimulus pushes the hand-computed state expected
// after each edge. A monitor pops one entry after every edge and compares it.
module tb_locker;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] Code = 4'h0;
    logic       Mode = 1'b1;
    logic       Unlock, Err, alert;
    logic [6:0] digits;

    int errors = 0;
    int checks = 0;
    int step_no = 0;
    logic [9:0] exp_q[$];

    locker dut (
        .CLK(CLK), .RST(RST), .Code(Code), .Mode(Mode),
        .Unlock(Unlock), .Err(Err), .alert(alert), .digits(digits)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[d];
    endfunction

    // Drive one edge's inputs. Push the expected {Unlock,Err,alert,digits} after that edge.
    // dc is the digit the display should show afterwards.
    task automatic step(input logic r, input logic m, input logic [3:0] c,
                        input logic u, input logic e, input logic a, input logic [3:0] dc);
        @(negedge CLK);
        RST  = r;
        Mode = m;
        Code = c;
        exp_q.push_back({u, e, a, glyph(dc)});
    endtask

    // Validate-mode digit with normal display echo.
    task automatic v(input logic [3:0] c, input logic u, input logic e, input logic a);
        step(1'b0, 1'b1, c, u, e, a, c);
    endtask

    task automatic s(input logic [3:0] c, input logic u, input logic e, input logic a);
        step(1'b0, 1'b0, c, u, e, a, c);
    endtask

    // Monitor: compare the DUT outputs after each edge against the scoreboard.
    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [9:0] ex;
            logic [9:0] act;
            ex  = exp_q.pop_front();
            act = {Unlock, Err, alert, digits};
            step_no++;
            checks++;
            if (act !== ex) begin
                errors++;
                $display("FAIL step%0d outputs: got U=%b E=%b A=%b dig=%b, want U=%b E=%b A=%b dig=%b",
                         step_no, act[9], act[8], act[7], act[6:0], ex[9], ex[8], ex[7], ex[6:0]);
            end
        end
    end

    initial begin
        // REQ-021 style: reset, then the default password unlocks.
        step(1'b1, 1'b1, 4'h5, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h3, 1, 0, 0);

        // Wrong code, set a new password, use it, then the old password fails.
        step(1'b1, 1'b1, 4'h0, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h4, 0, 1, 0);
        s(4'h5, 0, 0, 0); s(4'h6, 0, 0, 0); s(4'h7, 0, 0, 0); s(4'h8, 0, 0, 0);
        v(4'h5, 0, 0, 0); v(4'h6, 0, 0, 0); v(4'h7, 0, 0, 0); v(4'h8, 1, 0, 0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h3, 0, 1, 0);

        // Three failures give lockout. The user password is refused during lockout.
        // Set mode is ignored. The admin password clears the lockout.
        step(1'b1, 1'b1, 4'h0, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h4, 0, 1, 0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h4, 0, 1, 0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h4, 0, 1, 1);
        v(4'h0, 0, 0, 1); v(4'h1, 0, 0, 1); v(4'h0, 0, 0, 1); v(4'h3, 0, 1, 1);
        step(1'b0, 1'b0, 4'h1, 0, 1, 1, 4'h3);
        step(1'b0, 1'b0, 4'h2, 0, 1, 1, 4'h3);
        step(1'b0, 1'b0, 4'h3, 0, 1, 1, 4'h3);
        step(1'b0, 1'b0, 4'h4, 0, 1, 1, 4'h3);
        v(4'h0, 0, 0, 1); v(4'h2, 0, 0, 1); v(4'h0, 0, 0, 1); v(4'h7, 1, 0, 0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h3, 1, 0, 0);

        // A reset in the middle of a sequence discards the captured digits.
        step(1'b1, 1'b1, 4'h0, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0);
        step(1'b1, 1'b1, 4'h9, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h3, 0, 0, 0);
        step(1'b1, 1'b1, 4'h0, 0, 0, 0, 4'h0);
        v(4'h0, 0, 0, 0); v(4'h1, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h3, 1, 0, 0);

        // Hex digits A..F, the admin password in normal mode, and a Mode change that restarts the index.
        s(4'hA, 0, 0, 0); s(4'hB, 0, 0, 0); s(4'hC, 0, 0, 0); s(4'hF, 0, 0, 0);
        v(4'hA, 0, 0, 0); v(4'hB, 0, 0, 0); v(4'hC, 0, 0, 0); v(4'hF, 1, 0, 0);
        v(4'hA, 0, 0, 0); v(4'hB, 0, 0, 0); v(4'hC, 0, 0, 0); v(4'hE, 0, 1, 0);
        v(4'h0, 0, 0, 0); v(4'h2, 0, 0, 0); v(4'h0, 0, 0, 0); v(4'h7, 1, 0, 0);
        v(4'h0, 0, 0, 0); v(4'h2, 0, 0, 0);
        s(4'hD, 0, 0, 0); s(4'hD, 0, 0, 0);
        v(4'hA, 0, 0, 0); v(4'hB, 0, 0, 0); v(4'hC, 0, 0, 0); v(4'hF, 1, 0, 0);

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge CLK);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
